register_table_param: RTL and testbench

- Parametrised successor to the single-cycle register table.
- Three combinational read ports (a, b, d) and one synchronous write port; width, depth and register-0 behaviour are configurable.
- Adds a hardware init sweep: after reset or on request, every register is loaded with a programmed value, one register per cycle.
- A ready flag gates architectural access. Sits in the decode stage of the single-cycle and future pipelined cores.

---
 rtl/register_table_param.sv | 126 ++++++++++++
 tb/tb_register_table_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/register_table_param.sv
`default_nettype none
// =============================================================================
// register_table_param -- 3-read / 1-write register table with hardware init
// sweep; optional write-to-read forwarding via REGFILE_BYPASS_EN.  Rev 1.0
// =============================================================================
module register_table_param #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 32,
  parameter int ZERO_REG   = 1,
  parameter int INIT_INDEX = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] register_a,
  input  logic [ADDR_W-1:0] register_b,
  input  logic [ADDR_W-1:0] register_d,
  input  logic [DATA_W-1:0] data_register_d_in,
  input  logic              write_register_d,
  input  logic              clear_req,
  output logic [DATA_W-1:0] data_register_a,
  output logic [DATA_W-1:0] data_register_b,
  output logic [DATA_W-1:0] data_register_d_out,
  output logic              ready,
  output logic              write_accept
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]        state;
  logic [PTR_W-1:0]  ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] init_value;

  logic [ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0] rd_data [3];

  // Address is architecturally visible: implemented and not the hardwired zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_A) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  assign ready        = (state == ST_READY);
  assign write_accept = write_register_d && ready && !clear_req && addr_ok(register_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clear_req) begin
            ptr <= '0;
          end else if (ptr == LAST_PTR) begin
            state <= ST_READY;
            ptr   <= '0;
          end else begin
            ptr <= ptr + PTR_W'(1);
          end
        end
        ST_READY: begin
          if (clear_req) begin
            state <= ST_CLEAR;
            ptr   <= '0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          ptr   <= '0;
        end
      endcase
    end
  end

  generate
    if (INIT_INDEX != 0) begin : g_init_index
      logic [PTR_W:0] ptr_p1;
      assign ptr_p1     = {1'b0, ptr} + (PTR_W + 1)'(1);
      assign init_value = DATA_W'(ptr_p1);
    end else begin : g_init_zero
      assign init_value = '0;
    end
  endgenerate

  // Storage carries no reset; the sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[ptr] <= init_value;
    end else if (write_accept) begin
      mem[register_d[PTR_W-1:0]] <= data_register_d_in;
    end
  end

  assign rd_addr[0] = register_a;
  assign rd_addr[1] = register_b;
  assign rd_addr[2] = register_d;

  generate
    for (genvar p = 0; p < 3; p++) begin : g_rd
      logic [DATA_W-1:0] stored;
      logic              visible;
      assign stored  = mem[rd_addr[p][PTR_W-1:0]];
      assign visible = ready && addr_ok(rd_addr[p]);
`ifdef REGFILE_BYPASS_EN
      // Zero-forcing wins over forwarding.
      assign rd_data[p] = !visible ? '0 :
                          (write_accept && (rd_addr[p] == register_d)) ? data_register_d_in :
                          stored;
`else
      assign rd_data[p] = visible ? stored : '0;
`endif
    end
  endgenerate

  assign data_register_a     = rd_data[0];
  assign data_register_b     = rd_data[1];
  assign data_register_d_out = rd_data[2];

endmodule
`default_nettype wire

// File: tb/tb_register_table_param.sv
`default_nettype none
// tb_register_table_param -- scoreboard bench with randomized traffic against
// a behavioural register-table model.
module tb_register_table_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] register_a = '0;
  logic [AW-1:0] register_b = '0;
  logic [AW-1:0] register_d = '0;
  logic [DW-1:0] data_register_d_in = '0;
  logic          write_register_d = 1'b0;
  logic          clear_req = 1'b0;
  logic [DW-1:0] data_register_a;
  logic [DW-1:0] data_register_b;
  logic [DW-1:0] data_register_d_out;
  logic          ready;
  logic          write_accept;

  register_table_param #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .ZERO_REG(1), .INIT_INDEX(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .register_a(register_a),
    .register_b(register_b),
    .register_d(register_d),
    .data_register_d_in(data_register_d_in),
    .write_register_d(write_register_d),
    .clear_req(clear_req),
    .data_register_a(data_register_a),
    .data_register_b(data_register_b),
    .data_register_d_out(data_register_d_out),
    .ready(ready),
    .write_accept(write_accept)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        wa;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: table contents, ready flag, sweep position.
  logic [31:0] m_mem [32];
  logic        m_ready = 1'b0;
  int          m_pos   = 0;

  function automatic logic [31:0] exp_rd(input int x, input logic wa, input int d,
                                         input logic [31:0] din);
    bit byp;
    byp = 1'b0;
`ifdef REGFILE_BYPASS_EN
    byp = 1'b1;
`endif
    if (!m_ready || x >= DEPTH || x == 0) return 32'h0;
    if (byp && wa && x == d) return din;
    return m_mem[x];
  endfunction

  task automatic cycle(input logic rv, input int a, input int b, input int d,
                       input logic [31:0] din, input logic we, input logic clr);
    exp_t e;
    logic wa;
    @(posedge clk);
    #1;
    rst_n              = rv;
    register_a         = 5'(a);
    register_b         = 5'(b);
    register_d         = 5'(d);
    data_register_d_in = din;
    write_register_d   = we;
    clear_req          = clr;
    if (!rv) begin
      m_ready = 1'b0;
      m_pos   = 0;
    end
    wa    = we && m_ready && !clr && (d < DEPTH) && (d != 0);
    e.rdy = m_ready;
    e.wa  = wa;
    e.a   = exp_rd(a, wa, d, din);
    e.b   = exp_rd(b, wa, d, din);
    e.d   = exp_rd(d, wa, d, din);
    q.push_back(e);
    // Effect of the coming clock edge.
    if (rv) begin
      if (!m_ready) begin
        m_mem[m_pos] = 32'(m_pos + 1);
        if (clr) m_pos = 0;
        else if (m_pos == DEPTH - 1) begin
          m_ready = 1'b1;
          m_pos   = 0;
        end else m_pos++;
      end else if (clr) begin
        m_ready = 1'b0;
        m_pos   = 0;
      end else if (wa) begin
        m_mem[d] = din;
      end
    end
  endtask

  task automatic idle(input int n, input int a, input int b);
    for (int i = 0; i < n; i++) cycle(1'b1, a, b, int'($urandom_range(31, 0)), 32'h0, 1'b0, 1'b0);
  endtask

  task automatic random_traffic(input int n);
    int d;
    for (int i = 0; i < n; i++) begin
      d = int'($urandom_range(31, 0));
      cycle(1'b1,
            ($urandom_range(1, 0) != 0) ? d : int'($urandom_range(31, 0)),
            int'($urandom_range(31, 0)), d, $urandom,
            logic'($urandom_range(1, 0)), logic'($urandom_range(39, 0) == 0));
    end
  endtask

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", n, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ready", 32'(ready), 32'(e.rdy));
      chk("write_accept", 32'(write_accept), 32'(e.wa));
      chk("data_a", data_register_a, e.a);
      chk("data_b", data_register_b, e.b);
      chk("data_d", data_register_d_out, e.d);
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 3, 0, 0, 32'h0, 1'b0, 1'b0);
    // Sweep then idle reads of registers 3 and 0.
    idle(DEPTH + 4, 3, 0);
    // Write 7, same-cycle and next-cycle reads.
    cycle(1'b1, 7, 7, 7, 32'hDEADBEEF, 1'b1, 1'b0);
    cycle(1'b1, 7, 7, 7, 32'h0, 1'b0, 1'b0);
    // Register 0 write is dropped.
    cycle(1'b1, 0, 0, 0, 32'h12345678, 1'b1, 1'b0);
    cycle(1'b1, 0, 0, 0, 32'h0, 1'b0, 1'b0);
    // Out-of-range write and boundary register.
    cycle(1'b1, 30, 23, 30, 32'hCAFEF00D, 1'b1, 1'b0);
    cycle(1'b1, 30, 23, 23, 32'h0, 1'b0, 1'b0);
    // Clear collides with a write to 5.
    cycle(1'b1, 5, 5, 5, 32'hAAAA5555, 1'b1, 1'b1);
    idle(DEPTH + 3, 5, 23);
    random_traffic(400);
    // Reset 10 cycles into a sweep.
    cycle(1'b1, 4, 5, 6, 32'h0, 1'b0, 1'b1);
    idle(10, 4, 5);
    cycle(1'b0, 4, 5, 6, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 4, 5, 6, 32'h0, 1'b0, 1'b0);
    idle(DEPTH + 3, 4, 5);
    random_traffic(150);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
